signed_pow2_divider_pipelined: RTL and testbench
================================================

// Module: signed_pow2_divider_pipelined
// PURPOSE
//  Pipelined, run-time-variable signed shift / divide-by-2^s unit with valid/ready on both sides.
//  mode 0 (floor) gives arithmetic right shift a >>> s. mode 1 gives signed divide a / 2^s,
//  truncated toward zero (C semantics). Also reports whether any nonzero bits were discarded.
//  Sits in the arithmetic datapath between producer and consumer stages that may stall.
// PARAMETERS
//  N    8             data width, power of two, N >= 4
//  SW   $clog2(N)     shift-amount width (derived, do not override)
// PORTS
//  clk         in   1    single clock, all logic on posedge
//  rst         in   1    reset, synchronous, active-low (0 = reset)
//  up_valid    in   1    input beat present
//  up_ready    out  1    block can accept a beat this cycle
//  up_data     in   N    dividend a, two's complement
//  up_shift    in   SW   shift amount s, 0..N-1
//  up_mode     in   1    0 = floor (>>>), 1 = truncate toward zero
//  down_valid  out  1    result beat present
//  down_ready  in   1    consumer accepts result this cycle
//  down_data   out  N    result, two's complement
//  down_inexact out 1    1 if a is not an exact multiple of 2^s
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-low. Under reset all stage valids
//   clear; down_valid=0, down_data=0, down_inexact=0; up_ready=1 on the first cycle after release.
//  Transfer rule: beat moves on a side when valid && ready on the same posedge.
//  Pipeline: 1+SW register stages. P0 = bias, P1..PSW = log shifter (Pk shifts by 2^(k-1) if s[k-1]).
//  Latency with down_ready held 1: result valid exactly 1+SW cycles after acceptance (4 for N=8).
//  P0 bias: if mode==1 and a[N-1]==1, add (2^s - 1) to a in N bits. It never overflows for s<=N-1.
//   Otherwise bias=0. The bias is computed from s directly, not from the shift stages.
//  Shift stages: vacated MSBs fill with sign bit of the P0 value; s=0 passes data unchanged.
//  inexact: OR of the ORIGINAL a bits [s-1:0] (0 when s=0). It is computed in P0, carried as sticky.
//   It is independent of mode.
//  Flow control: per-stage bubble-collapsing. Stage k loads when !valid_k || ready_(k+1).
//   The last stage's ready is down_ready. up_ready = !valid_0 || ready_1 (combinational).
//  Capacity 1+SW beats. With down_ready=0 exactly 1+SW beats are accepted, then up_ready=0.
//  Stalled stage holds data, shift, mode, sticky stable. down_data/down_inexact stay stable while
//   down_valid && !down_ready.
//  Ordering: strictly in order; no beat dropped or duplicated under any valid/ready pattern.
//  Simultaneous accept on up side and emit on down side in a full pipe is allowed at full throughput.
//  Throughput: 1 beat/cycle when down_ready=1.
//  up_shift/up_mode/up_data are sampled only on up transfer. Values when !up_valid are ignored.
//  Mid-operation reset: all in-flight beats discarded; down_valid drops the cycle after rst sampled 0.
//  Data regs need no reset except down_data/down_inexact.
// TESTING  (N=8, latency 4)
//  a=0xF9(-7), s=1, mode0 -> 0xFC(-4), inexact=1; same with mode1 -> 0xFD(-3), inexact=1.
//  a=0x80(-128), s=7, mode0 and mode1 -> 0xFF(-1), inexact=0. a=0x64(100), s=3 -> 0x0C, inexact=1
//   in both modes. a=0x7F, s=0 -> 0x7F, inexact=0.
//  Back-to-back 16 random beats, down_ready=1 -> results 4 cycles after each accept, 1/cycle,
//   match golden (mode0 a>>>s, mode1 a/2^s).
//  down_ready=0, up_valid=1 -> exactly 4 beats accepted, then up_ready=0. Release down_ready ->
//   4 results in order, then flow resumes.
//  Random valid/ready toggling on both sides, 1000 beats -> scoreboard: no loss, dup or reorder.
//   Output is stable under stall.
//  rst=0 for one cycle with pipe full -> next cycle down_valid=0, down_data=0, up_ready=1.
//   No stale beats appear afterwards.

Source files
------------

// File: rtl/signed_pow2_divider_pipelined_if.sv
// rtl/signed_pow2_divider_pipelined_if.sv - upstream/downstream handshake bundle for the pow2 divider
interface signed_pow2_divider_pipelined_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shift;
  logic          up_mode;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          down_inexact;

  modport slave (
    input  up_valid, up_data, up_shift, up_mode, down_ready,
    output up_ready, down_valid, down_data, down_inexact
  );

  modport master (
    output up_valid, up_data, up_shift, up_mode, down_ready,
    input  up_ready, down_valid, down_data, down_inexact
  );
endinterface

// File: rtl/signed_pow2_divider_pipelined.sv
// rtl/signed_pow2_divider_pipelined.sv - pipelined signed shift / divide by 2^s with valid/ready
// Stage 0 applies the round-toward-zero bias and sticky; stages 1..SW form a log shifter.
module signed_pow2_divider_pipelined #(
  parameter int N = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  signed_pow2_divider_pipelined_if.slave     bus
);
  localparam int SW = $clog2(N);

  logic [SW:0]   r_valid;
  logic [N-1:0]  r_data   [0:SW];
  logic [SW-1:0] r_shift  [0:SW];
  logic [SW:0]   r_sticky;

  logic [SW:0]   w_ready;
  logic [N-1:0]  w_mask;
  logic [N-1:0]  w_bias;
  logic [N-1:0]  w_biased;
  logic          w_inexact;

  always_comb begin
    w_mask    = (N'(1) << bus.up_shift) - N'(1);
    w_bias    = (bus.up_mode && bus.up_data[N-1]) ? w_mask : '0;
    w_biased  = bus.up_data + w_bias;
    w_inexact = |(bus.up_data & w_mask);
  end

  // A stage may load when it or any stage downstream of it holds a bubble, or the consumer drains.
  always_comb begin
    logic v_acc;
    w_ready = '0;
    v_acc   = bus.down_ready;
    for (int k = SW; k >= 0; k--) begin
      v_acc      = v_acc || !r_valid[k];
      w_ready[k] = v_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= '0;
      r_data[SW]   <= '0;
      r_sticky[SW] <= 1'b0;
    end else begin
      if (w_ready[0]) begin
        r_valid[0]  <= bus.up_valid;
        r_data[0]   <= w_biased;
        r_shift[0]  <= bus.up_shift;
        r_sticky[0] <= w_inexact;
      end
      for (int k = 1; k <= SW; k++) begin
        if (w_ready[k]) begin
          r_valid[k]  <= r_valid[k-1];
          r_data[k]   <= r_shift[k-1][k-1] ? ($signed(r_data[k-1]) >>> (2 ** (k - 1)))
                                           : $signed(r_data[k-1]);
          r_shift[k]  <= r_shift[k-1];
          r_sticky[k] <= r_sticky[k-1];
        end
      end
    end
  end

  assign bus.up_ready     = w_ready[0];
  assign bus.down_valid   = r_valid[SW];
  assign bus.down_data    = r_data[SW];
  assign bus.down_inexact = r_sticky[SW];
endmodule

// File: tb/tb_signed_pow2_divider_pipelined.sv
// tb/tb_signed_pow2_divider_pipelined.sv - directed and scoreboarded checks of the pow2 divider
module tb_signed_pow2_divider_pipelined;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signed_pow2_divider_pipelined_if #(.N(8)) bus ();
  signed_pow2_divider_pipelined #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] d;
    logic       inx;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       lat_chk = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] hold_d;
  logic       hold_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] gold(input logic [7:0] a, input logic [2:0] s, input logic m);
    int ai;
    int q;
    int msk;
    ai  = int'($signed(a));
    msk = (1 << s) - 1;
    if (m) q = ai / (1 << s);
    else   q = ai >>> s;
    return {((ai & msk) != 0), q[7:0]};
  endfunction

  task automatic step(input logic uv, input logic [7:0] a, input logic [2:0] s, input logic m,
                      input logic dr, input logic [7:0] ed, input logic ei, output logic took);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (hold) begin
      chk("stall_valid", 32'(bus.down_valid), 32'd1);
      chk("stall_data", 32'(bus.down_data), 32'(hold_d));
      chk("stall_inexact", 32'(bus.down_inexact), 32'(hold_i));
    end
    bus.up_valid   = uv;
    bus.up_data    = a;
    bus.up_shift   = s;
    bus.up_mode    = m;
    bus.down_ready = dr;
    #1;
    took = uv && bus.up_ready;
    if (bus.down_valid && dr) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", 32'(bus.down_data), 32'(e.d));
        chk("inexact", 32'(bus.down_inexact), 32'(e.inx));
        if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd4);
      end
    end
    hold   = bus.down_valid && !dr;
    hold_d = bus.down_data;
    hold_i = bus.down_inexact;
    if (took) exp_q.push_back('{ed, ei, cyc});
  endtask

  task automatic send_rand(input logic uv, input logic dr, output logic took);
    logic [7:0] a;
    logic [2:0] s;
    logic       m;
    logic [8:0] g;
    a = 8'($urandom);
    s = 3'($urandom);
    m = 1'($urandom);
    g = gold(a, s, m);
    step(uv, a, s, m, dr, g[7:0], g[8], took);
  endtask

  task automatic send_dir(input logic [7:0] a, input logic [2:0] s, input logic m,
                          input logic [7:0] ed, input logic ei);
    logic took;
    took = 1'b0;
    for (int t = 0; t < 8 && !took; t++) step(1'b1, a, s, m, 1'b1, ed, ei, took);
    chk("dir_accept", 32'(took), 32'd1);
  endtask

  task automatic idle(input int n);
    logic took;
    repeat (n) step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0, took);
  endtask

  initial begin
    logic took;
    int   cnt;
    rst            = 1'b0;
    bus.up_valid   = 1'b0;
    bus.up_data    = 8'h00;
    bus.up_shift   = 3'd0;
    bus.up_mode    = 1'b0;
    bus.down_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.down_valid), 32'd0);
    chk("reset_data", 32'(bus.down_data), 32'd0);
    chk("reset_inexact", 32'(bus.down_inexact), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(bus.up_ready), 32'd1);

    // hand-computed vectors, back to back, latency checked
    lat_chk = 1'b1;
    send_dir(8'hF9, 3'd1, 1'b0, 8'hFC, 1'b1);
    send_dir(8'hF9, 3'd1, 1'b1, 8'hFD, 1'b1);
    send_dir(8'h80, 3'd7, 1'b0, 8'hFF, 1'b0);
    send_dir(8'h80, 3'd7, 1'b1, 8'hFF, 1'b0);
    send_dir(8'h64, 3'd3, 1'b0, 8'h0C, 1'b1);
    send_dir(8'h64, 3'd3, 1'b1, 8'h0C, 1'b1);
    send_dir(8'h7F, 3'd0, 1'b0, 8'h7F, 1'b0);
    send_dir(8'h7F, 3'd0, 1'b1, 8'h7F, 1'b0);
    send_dir(8'hF9, 3'd3, 1'b0, 8'hFF, 1'b1);
    send_dir(8'hF9, 3'd3, 1'b1, 8'h00, 1'b1);
    send_dir(8'hF8, 3'd3, 1'b1, 8'hFF, 1'b0);
    send_dir(8'h81, 3'd7, 1'b1, 8'h00, 1'b1);
    idle(8);
    chk("drain_directed", 32'(exp_q.size()), 32'd0);

    cnt = 0;
    repeat (16) begin
      send_rand(1'b1, 1'b1, took);
      cnt += int'(took);
    end
    chk("b2b_accepts", 32'(cnt), 32'd16);
    idle(8);
    chk("drain_b2b", 32'(exp_q.size()), 32'd0);
    lat_chk = 1'b0;

    cnt = 0;
    repeat (8) begin
      send_rand(1'b1, 1'b0, took);
      cnt += int'(took);
    end
    chk("capacity", 32'(cnt), 32'd4);
    chk("full_not_ready", 32'(bus.up_ready), 32'd0);
    idle(8);
    chk("stall_release", 32'(exp_q.size()), 32'd0);
    cnt = 0;
    repeat (6) begin
      send_rand(1'b1, 1'b1, took);
      cnt += int'(took);
    end
    chk("resume", 32'(cnt), 32'd6);
    idle(8);
    chk("drain_resume", 32'(exp_q.size()), 32'd0);

    cnt = 0;
    for (int g = 0; g < 20000 && cnt < 1000; g++) begin
      send_rand($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, took);
      cnt += int'(took);
    end
    chk("random_beats", 32'(cnt), 32'd1000);
    idle(40);
    chk("drain_random", 32'(exp_q.size()), 32'd0);

    repeat (6) send_rand(1'b1, 1'b0, took);
    chk("prefill", 32'(exp_q.size()), 32'd4);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.up_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midrst_valid", 32'(bus.down_valid), 32'd0);
    chk("midrst_data", 32'(bus.down_data), 32'd0);
    chk("midrst_inexact", 32'(bus.down_inexact), 32'd0);
    chk("midrst_ready", 32'(bus.up_ready), 32'd1);
    exp_q.delete();
    hold = 1'b0;
    idle(10);
    send_dir(8'h9C, 3'd2, 1'b1, 8'hE7, 1'b0);
    send_dir(8'h9D, 3'd2, 1'b0, 8'hE7, 1'b1);
    idle(8);
    chk("drain_after_reset", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
